// File: rtl/tag_mem_array.sv
// Tag memory storage responder: EPC, sensor1 and sensor2 banks behind
// the precharge/sense/write handshake, one-cycle registered read data.
module tag_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PC_B,
  input  logic              SE,
  input  logic              WE,
  input  logic [1:0]        RorW,
  input  logic [2:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] mem_read_in,
  output logic              read_valid,
  output logic              mem_busy,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    RD,
    WR
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] a_lat;
  logic [2:0]        b_lat;

  logic [DATA_W-1:0] epc [DEPTH];
  logic [DATA_W-1:0] sen1 [DEPTH];
  logic [DATA_W-1:0] sen2 [DEPTH];

  logic              is_read;
  logic              is_write;
  logic              addr_ok;
  logic              access_ok;
  logic              restart;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign is_read  = (RorW == 2'b01);
  assign is_write = (RorW == 2'b10);
  assign addr_ok  = {{(32-ADDR_W){1'b0}}, mem_address} < 32'(DEPTH);
  assign access_ok = $onehot(mem_sel) && addr_ok;

  // WR is the only state that ignores a new precharge
  assign restart = !PC_B && (state != WR);

  assign wr_en = (state == PRE) && PC_B && WE && !SE && is_write;

  assign mem_busy = (state != IDLE);

  // Read data is fetched with the live address so it lands on the latch edge
  always_comb begin
    rd_data = '0;
    case (mem_sel)
      3'b001:  rd_data = epc[mem_address];
      3'b010:  rd_data = sen1[mem_address];
      3'b100:  rd_data = sen2[mem_address];
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (b_lat)
        3'b001:  epc[a_lat]  <= mem_data_out;
        3'b010:  sen1[a_lat] <= mem_data_out;
        3'b100:  sen2[a_lat] <= mem_data_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_lat       <= '0;
      b_lat       <= '0;
      mem_read_in <= '0;
      read_valid  <= 1'b0;
      mem_err     <= 1'b0;
    end else if (restart) begin
      a_lat <= mem_address;
      b_lat <= mem_sel;
      if (!access_ok) begin
        mem_err    <= 1'b1;
        read_valid <= 1'b0;
        state      <= IDLE;
      end else begin
        mem_err    <= 1'b0;
        read_valid <= is_read;
        state      <= PRE;
        if (is_read)
          mem_read_in <= rd_data;
      end
    end else begin
      case (state)
        PRE: begin
          if (WE && SE) begin
            mem_err    <= 1'b1;
            read_valid <= 1'b0;
            state      <= IDLE;
          end else if (WE && is_write) begin
            state <= WR;
          end else if (SE && is_read) begin
            state <= RD;
          end
        end
        RD: begin
          if (!SE) begin
            read_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        WR: begin
          if (!WE)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_mem_array.sv
// Directed bench for tag_mem_array: bank writes/reads, write-once,
// fault flag, reset mid-write and back-to-back reads.
module tb_tag_mem_array;

  logic        clk;
  logic        reset_n;
  logic        PC_B;
  logic        SE;
  logic        WE;
  logic [1:0]  RorW;
  logic [2:0]  mem_sel;
  logic [5:0]  mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_read_in;
  logic        read_valid;
  logic        mem_busy;
  logic        mem_err;

  int n_checks;
  int n_fail;

  tag_mem_array #(
    .DATA_W(16),
    .ADDR_W(6),
    .DEPTH (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .PC_B        (PC_B),
    .SE          (SE),
    .WE          (WE),
    .RorW        (RorW),
    .mem_sel     (mem_sel),
    .mem_address (mem_address),
    .mem_data_out(mem_data_out),
    .mem_read_in (mem_read_in),
    .read_valid  (read_valid),
    .mem_busy    (mem_busy),
    .mem_err     (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC_B = 1'b1;
    SE   = 1'b0;
    WE   = 1'b0;
    RorW = 2'b00;
  endtask

  task automatic do_write(input logic [2:0] sel, input logic [5:0] addr,
                          input logic [15:0] data);
    PC_B = 1'b0; mem_sel = sel; mem_address = addr; RorW = 2'b10;
    step();
    PC_B = 1'b1; WE = 1'b1; mem_data_out = data;
    step();
    WE = 1'b0;
    step();
    idle_inputs();
  endtask

  // Full read handshake; returns the word sampled after the PC_B-low edge
  task automatic do_read(input logic [2:0] sel, input logic [5:0] addr,
                         output logic [15:0] data, output logic rv);
    PC_B = 1'b0; mem_sel = sel; mem_address = addr; RorW = 2'b01;
    step();
    data = mem_read_in;
    rv   = read_valid;
    PC_B = 1'b1; SE = 1'b1;
    step();
    SE = 1'b0;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    mem_sel = 3'b000; mem_address = '0; mem_data_out = '0;
    #12;
    n_checks++;
    if ({mem_read_in, read_valid, mem_busy, mem_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%h rv=%b busy=%b err=%b want 0",
               mem_read_in, read_valid, mem_busy, mem_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write_read_epc();
    logic [15:0] d;
    logic rv;
    do_write(3'b001, 6'd5, 16'hA5C3);
    PC_B = 1'b0; mem_sel = 3'b001; mem_address = 6'd5; RorW = 2'b01;
    step();
    n_checks++;
    if (mem_read_in !== 16'hA5C3 || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL epc_read_latency: got %h rv=%b want a5c3 rv=1",
               mem_read_in, read_valid);
    end
    PC_B = 1'b1; SE = 1'b1;
    mem_address = 6'd0;
    step();
    n_checks++;
    if (read_valid !== 1'b1 || mem_read_in !== 16'hA5C3 || mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL epc_read_hold: got %h rv=%b busy=%b want a5c3 1 1",
               mem_read_in, read_valid, mem_busy);
    end
    SE = 1'b0;
    step();
    n_checks++;
    if (read_valid !== 1'b0 || mem_read_in !== 16'hA5C3 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL epc_read_end: got %h rv=%b busy=%b want a5c3 0 0",
               mem_read_in, read_valid, mem_busy);
    end
    idle_inputs();
    do_read(3'b001, 6'd5, d, rv);
  endtask

  task automatic test_bank_isolation();
    logic [15:0] d;
    logic rv;
    do_write(3'b001, 6'd0, 16'h0E0E);
    do_write(3'b010, 6'd0, 16'h1111);
    do_write(3'b100, 6'd0, 16'h2222);
    do_read(3'b010, 6'd0, d, rv);
    n_checks++;
    if (d !== 16'h1111 || rv !== 1'b1) begin
      n_fail++;
      $display("FAIL iso_sensor1: got %h rv=%b want 1111 1", d, rv);
    end
    do_read(3'b100, 6'd0, d, rv);
    n_checks++;
    if (d !== 16'h2222) begin
      n_fail++;
      $display("FAIL iso_sensor2: got %h want 2222", d);
    end
    do_read(3'b001, 6'd0, d, rv);
    n_checks++;
    if (d !== 16'h0E0E) begin
      n_fail++;
      $display("FAIL iso_epc: got %h want 0e0e", d);
    end
  endtask

  task automatic test_write_once();
    logic [15:0] d;
    logic rv;
    PC_B = 1'b0; mem_sel = 3'b010; mem_address = 6'd12; RorW = 2'b10;
    step();
    PC_B = 1'b1; WE = 1'b1; mem_data_out = 16'h0001;
    step();
    mem_data_out = 16'h0002;
    step();
    mem_data_out = 16'h0003;
    step();
    WE = 1'b0;
    step();
    idle_inputs();
    do_read(3'b010, 6'd12, d, rv);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL write_once: got %h want 0001", d);
    end
  endtask

  task automatic test_faults();
    logic [15:0] d;
    logic rv;
    do_write(3'b001, 6'd7, 16'h7777);
    PC_B = 1'b0; mem_sel = 3'b011; mem_address = 6'd7; RorW = 2'b10;
    step();
    n_checks++;
    if (mem_err !== 1'b1 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel: got err=%b busy=%b want 1 0", mem_err, mem_busy);
    end
    PC_B = 1'b1; WE = 1'b1; mem_data_out = 16'hDEAD;
    step();
    n_checks++;
    if (mem_err !== 1'b1 || mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_sticky: got err=%b busy=%b want 1 0",
               mem_err, mem_busy);
    end
    idle_inputs();
    step();
    do_read(3'b001, 6'd7, d, rv);
    n_checks++;
    if (d !== 16'h7777 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_nowrite: got %h err=%b want 7777 0", d, mem_err);
    end
    PC_B = 1'b0; mem_sel = 3'b001; mem_address = 6'd7; RorW = 2'b10;
    step();
    PC_B = 1'b1; WE = 1'b1; SE = 1'b1; mem_data_out = 16'hBEEF;
    step();
    n_checks++;
    if (mem_err !== 1'b1 || mem_busy !== 1'b0 || read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL we_se: got err=%b busy=%b rv=%b want 1 0 0",
               mem_err, mem_busy, read_valid);
    end
    idle_inputs();
    step();
    do_read(3'b001, 6'd7, d, rv);
    n_checks++;
    if (d !== 16'h7777 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL we_se_nowrite: got %h err=%b want 7777 0", d, mem_err);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] d;
    logic rv;
    PC_B = 1'b0; mem_sel = 3'b010; mem_address = 6'd9; RorW = 2'b10;
    step();
    PC_B = 1'b1; WE = 1'b1; mem_data_out = 16'h9999;
    step();
    n_checks++;
    if (mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL in_wr: got busy=%b want 1", mem_busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read_in, read_valid, mem_busy, mem_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid_write: got rd=%h rv=%b busy=%b err=%b want 0",
               mem_read_in, read_valid, mem_busy, mem_err);
    end
    step();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    do_read(3'b010, 6'd9, d, rv);
    n_checks++;
    if (d !== 16'h9999) begin
      n_fail++;
      $display("FAIL keep_s1_9: got %h want 9999", d);
    end
    do_read(3'b001, 6'd5, d, rv);
    n_checks++;
    if (d !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL keep_epc_5: got %h want a5c3", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [3];
    logic [5:0]  addr_w [3];
    logic [3:0]  busy_seen;
    exp_w[0] = 16'h3F3F; addr_w[0] = 6'd63;
    exp_w[1] = 16'h3E3E; addr_w[1] = 6'd62;
    exp_w[2] = 16'h3D3D; addr_w[2] = 6'd61;
    for (int i = 0; i < 3; i++)
      do_write(3'b100, addr_w[i], exp_w[i]);
    for (int i = 0; i < 3; i++) begin
      PC_B = 1'b0; mem_sel = 3'b100; mem_address = addr_w[i]; RorW = 2'b01;
      step();
      busy_seen[3] = mem_busy;
      n_checks++;
      if (mem_read_in !== exp_w[i] || read_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_data_%0d: got %h rv=%b want %h 1",
                 i, mem_read_in, read_valid, exp_w[i]);
      end
      PC_B = 1'b1; SE = 1'b1;
      step();
      busy_seen[2] = mem_busy;
      SE = 1'b0;
      step();
      busy_seen[1] = mem_busy;
      idle_inputs();
      step();
      busy_seen[0] = mem_busy;
      n_checks++;
      if (busy_seen !== 4'b1100) begin
        n_fail++;
        $display("FAIL b2b_busy_%0d: got %b want 1100", i, busy_seen);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read_epc();
    test_bank_isolation();
    test_write_once();
    test_faults();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_mem_array.md
Name: tag_mem_array

Overview:
- Behavioural storage responder on the far side of the tag memory bus.
- Holds three banks: EPC (mem_sel=3'b001), sensor1 (3'b010) and sensor2 (3'b100).
- Answers the precharge/sense/write handshake driven by the memory interface: PC_B, SE, WE, mem_address, mem_sel, RorW.
- Returns read data on mem_read_in and commits write data from mem_data_out, with a fixed one-cycle read latency the initiator depends on.

Parameters:
- DATA_W, 16, word width of every bank.
- ADDR_W, 6, width of mem_address.
- DEPTH, 64, words per bank; valid addresses are 0..DEPTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- PC_B  input  1  precharge, active low; a sampled low value starts an access and latches address/bank.
- SE  input  1  sense enable (read phase).
- WE  input  1  write enable (write phase).
- RorW  input  2  2'b01 = read, 2'b10 = write; other values = no access.
- mem_sel  input  3  one-hot bank select.
- mem_address  input  ADDR_W  word address.
- mem_data_out  input  DATA_W  write data from the initiator.
- mem_read_in  output  DATA_W  registered read data to the initiator.
- read_valid  output  1  high while mem_read_in holds data for the current read.
- mem_busy  output  1  high in any state other than IDLE.
- mem_err  output  1  access fault flag.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Control state goes to IDLE.
  - mem_read_in=0, read_valid=0, mem_busy=0, mem_err=0.
  - Latched address and bank clear to 0.
  - Array contents are NOT reset and are preserved across reset. A never-written location reads undefined; benches do not check it.
- States: IDLE, PRE, RD, WR.
- IDLE:
  - Stays in IDLE while PC_B=1.
  - On an edge sampling PC_B=0: latch mem_address to a_lat and mem_sel to b_lat.
  - If mem_sel is not one-hot, or mem_address >= DEPTH: set mem_err=1 and stay IDLE (no array access).
  - Otherwise: clear mem_err and go to PRE.
  - If that access is valid and RorW=2'b01, at the same edge load mem_read_in <= bank[b_lat][a_lat] and set read_valid=1.
  - Read latency: data is valid on the edge immediately after the PC_B-low edge. This is the edge where the initiator raises SE and samples mem_read_in.
- PRE:
  - PC_B=0 again: restart. Re-latch address/bank and repeat the IDLE checks and the read load; stay in PRE (or go to IDLE on error).
  - WE=1 and SE=1 together: set mem_err=1, perform no write, drop read_valid, go to IDLE.
  - WE=1 and RorW=2'b10: write bank[b_lat][a_lat] <= mem_data_out at this edge and go to WR.
  - SE=1 and RorW=2'b01: go to RD; mem_read_in is held.
  - Otherwise: remain in PRE. There is no timeout.
- RD:
  - Hold mem_read_in and read_valid=1 while SE=1.
  - On SE=0: read_valid=0, go to IDLE. mem_read_in keeps its last value (not cleared).
  - PC_B=0 in RD is treated as a new access: same handling as IDLE.
- WR:
  - Exactly one write per WE assertion. WE held high for further cycles does not rewrite, even if mem_data_out changes.
  - On WE=0: go to IDLE.
- Changes to mem_address or mem_sel after the PC_B-low edge are ignored; only the latched values are used.
- Read-after-write to the same bank/address returns the newly written word; no bypass is needed because accesses are serialized.
- mem_err is sticky until the next error-free PC_B-low edge or reset.
- Width rules: mem_address is compared unsigned against DEPTH. When DEPTH = 2^ADDR_W the range check never fires.

Test Plan:
- Write EPC: PC_B low with mem_sel=001, RorW=10, addr=5; next cycle PC_B=1, WE=1, mem_data_out=16'hA5C3 -> one write. Later read of addr 5 -> mem_read_in=16'hA5C3 one edge after PC_B low, read_valid=1 until SE drops.
- Bank isolation: write 16'h1111 to sensor1[0] and 16'h2222 to sensor2[0] -> reads return 16'h1111 and 16'h2222; EPC[0] unchanged.
- Hold WE high 3 cycles while mem_data_out changes 16'h0001 -> 16'h0002 -> 16'h0003 -> the location holds 16'h0001.
- Faults: mem_sel=011 on PC_B low -> mem_err=1, state stays IDLE, no write. WE and SE both high in PRE -> mem_err=1, no write. Next valid access -> mem_err=0.
- Reset mid-write: assert reset_n=0 while in WR -> outputs at reset values immediately. Previously written words still read back correctly after reset.
- Back-to-back reads at addresses 63, 62, 61 with the initiator timing (PC_B low / SE high / SE low / idle) -> three correct words, mem_busy low exactly in the idle cycles.
